mem_port_arbiter: RTL and testbench

Sequences the single-port data memory and shares it between two requesters: instruction fetch (IF, read-only) and the MEM pipeline stage (DM, read/write).
- Runs one access at a time through a small FSM, with a configurable read latency.
- Returns data and a one-cycle ack to the winning requester; the pipeline stalls on req && !ack.
- Sits between the pipeline stage registers and the data memory.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_arb_pick.sv | 19 +
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and default widths for the memory port arbiter
package mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signals of the arbiter
interface mem_port_arbiter_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - DM-priority pick with IF starvation override
module mem_arb_pick #(
  parameter int STARVE_LIMIT = 4,
  parameter int SW           = 3
) (
  input  logic          if_req,
  input  logic          dm_req,
  input  logic [SW-1:0] dm_streak,
  output logic          grant_if,
  output logic          grant_dm
);

  logic if_starved;

  assign if_starved = if_req && (dm_streak >= SW'(STARVE_LIMIT));
  assign grant_dm   = dm_req && !if_starved;
  assign grant_if   = if_req && !grant_dm;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port data memory shared by instruction fetch and MEM stage
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(READ_LATENCY - 1);

  state_t            state, state_nxt;
  owner_t            owner;
  logic [CNT_W-1:0]  cnt;
  logic [SW-1:0]     dm_streak;
  logic              grant_if, grant_dm;
  logic              start, finish, start_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] rd_word;

  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .SW           (SW)
  ) u_pick (
    .if_req    (bus.if_req),
    .dm_req    (bus.dm_req),
    .dm_streak (dm_streak),
    .grant_if  (grant_if),
    .grant_dm  (grant_dm)
  );

  assign req_addr = grant_dm ? bus.dm_addr : bus.if_addr;
  assign start_we = grant_dm && bus.dm_we;
  assign rd_word  = bus.mem_rdata;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_if || grant_dm) begin
          state_nxt = ACCESS;
          start     = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= OWN_NONE;
      cnt           <= '0;
      dm_streak     <= '0;
      bus.if_ack    <= 1'b0;
      bus.dm_ack    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      bus.if_ack <= 1'b0;
      bus.dm_ack <= 1'b0;

      if (start) begin
        owner        <= grant_dm ? OWN_DM : OWN_IF;
        bus.mem_addr <= req_addr;
        if (grant_dm) bus.mem_wdata <= bus.dm_wdata;
        bus.mem_we   <= start_we;
        cnt          <= start_we ? '0 : RD_CNT;
        // Streak only grows while IF is actually being held off.
        if (grant_dm && bus.if_req) begin
          if (dm_streak < SW'(STARVE_LIMIT)) dm_streak <= dm_streak + 1'b1;
        end else begin
          dm_streak <= '0;
        end
      end

      if (state == ACCESS && !finish) cnt <= cnt - 1'b1;

      if (finish) begin
        bus.mem_we <= 1'b0;
        if (owner == OWN_IF) begin
          bus.if_ack <= 1'b1;
          if (!bus.mem_we) bus.if_rdata <= rd_word;
        end else begin
          bus.dm_ack <= 1'b1;
          if (!bus.mem_we) bus.dm_rdata <= rd_word;
        end
      end

      if (state == DONE) owner <= OWN_NONE;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .STARVE_LIMIT(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3), .STARVE_LIMIT(4)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  // Word memory for the main instance; the RL=3 instance reads ~address.
  logic [31:0] mem [16];
  logic mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      mem_init_done <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata  = mem[bus.mem_addr[5:2]];
  assign bus3.mem_rdata = ~bus3.mem_addr;

  typedef struct {
    int          dut;
    int          who;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int we_cycles = 0;
  int we3_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int dut, input int who, input logic [31:0] data, input int at);
    exp_t e;
    e.dut = dut; e.who = who; e.data = data; e.cyc = at;
    sb.push_back(e);
  endtask

  exp_t        mon_e;
  int          act_dut, act_who;
  logic [31:0] act_data;
  logic [3:0]  acks;

  always @(negedge clk) begin
    if (bus.mem_we)  we_cycles++;
    if (bus3.mem_we) we3_cycles++;
    acks = {bus3.dm_ack, bus3.if_ack, bus.dm_ack, bus.if_ack};
    if (acks != 4'b0) begin
      check("ack_exclusive", 32'(acks[0] & acks[1]), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(acks), 32'd0);
      end else begin
        mon_e    = sb.pop_front();
        act_dut  = (acks[3:2] != 2'b0) ? 3 : 1;
        act_who  = (act_dut == 1) ? (acks[0] ? 1 : 2) : (acks[2] ? 1 : 2);
        act_data = (act_dut == 1) ? ((act_who == 1) ? bus.if_rdata : bus.dm_rdata)
                                  : ((act_who == 1) ? bus3.if_rdata : bus3.dm_rdata);
        check("ack_dut", 32'(act_dut), 32'(mon_e.dut));
        check("ack_owner", 32'(act_who), 32'(mon_e.who));
        check("ack_rdata", act_data, mon_e.data);
        if (mon_e.cyc >= 0) check("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Call with the arbiter idle, #1 after a rising edge; returns one cycle after ack.
  task automatic dm_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input bit push);
    int t;
    if (push) push_exp(1, 2, exp_data, cyc + 2);
    we_cycles   = 0;
    bus.dm_we   = we;
    bus.dm_addr = addr;
    bus.dm_wdata = wdata;
    bus.dm_req  = 1'b1;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!bus.dm_ack && t < 100);
    if (!bus.dm_ack) check("dm_timeout", 32'd0, 32'd1);
    bus.dm_req = 1'b0;
    if (we) check("dm_write_we_cycles", 32'(we_cycles), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic if_op(input int dut, input logic [31:0] addr, input logic [31:0] exp_data,
                       input bit push, input int lat);
    int t;
    logic ack;
    if (push) push_exp(dut, 1, exp_data, cyc + 1 + lat);
    if (dut == 1) begin bus.if_addr = addr;  bus.if_req = 1'b1;  end
    else          begin bus3.if_addr = addr; bus3.if_req = 1'b1; end
    t = 0;
    do begin
      @(posedge clk); #1; t++;
      ack = (dut == 1) ? bus.if_ack : bus3.if_ack;
    end while (!ack && t < 100);
    if (!ack) check("if_timeout", 32'd0, 32'd1);
    if (dut == 1) bus.if_req = 1'b0; else bus3.if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  int k;
  int c0;

  initial begin
    bus.if_req = 0;  bus.if_addr = 0;  bus.dm_req = 0;  bus.dm_we = 0;  bus.dm_addr = 0;  bus.dm_wdata = 0;
    bus3.if_req = 0; bus3.if_addr = 0; bus3.dm_req = 0; bus3.dm_we = 0; bus3.dm_addr = 0; bus3.dm_wdata = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_if_ack", 32'(bus.if_ack), 32'd0);
    check("rst_dm_ack", 32'(bus.dm_ack), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_dm_rdata", bus.dm_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // DM write then read-back at READ_LATENCY=1
    dm_op(1'b1, 32'h7FF0_0004, 32'hDEAD_BEEF, 32'h0, 1'b1);
    dm_op(1'b0, 32'h7FF0_0004, 32'h0, 32'hDEAD_BEEF, 1'b1);

    // IF alone on the READ_LATENCY=3 instance
    if_op(3, 32'h7FF0_0010, 32'h800F_FFEF, 1'b1, 3);
    check("if3_mem_we_cycles", 32'(we3_cycles), 32'd0);

    // Both held: DM x4, IF, DM x4, IF, DM
    k = cyc;
    for (int i = 0; i < 4; i++) push_exp(1, 2, 32'hDEAD_BEEF, k + 2 + 3 * i);
    push_exp(1, 1, 32'hA5A5_0004, k + 14);
    for (int i = 0; i < 4; i++) push_exp(1, 2, 32'hDEAD_BEEF, k + 17 + 3 * i);
    push_exp(1, 1, 32'hA5A5_0004, k + 29);
    push_exp(1, 2, 32'hDEAD_BEEF, k + 32);
    fork
      begin
        for (int i = 0; i < 9; i++) dm_op(1'b0, 32'h7FF0_0004, 32'h0, 32'h0, 1'b0);
      end
      begin
        for (int j = 0; j < 2; j++) if_op(1, 32'h7FF0_0010, 32'h0, 1'b0, 1);
      end
    join

    // Reset in the ACCESS cycle of a write aborts it
    bus.dm_we = 1'b1; bus.dm_addr = 32'h7FF0_0008; bus.dm_wdata = 32'hCAFE_F00D; bus.dm_req = 1'b1;
    @(posedge clk); #1;
    check("abort_we_before", 32'(bus.mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_we_now", 32'(bus.mem_we), 32'd0);
    check("abort_mem_addr", bus.mem_addr, 32'd0);
    check("abort_dm_ack", 32'(bus.dm_ack), 32'd0);
    bus.dm_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dm_op(1'b0, 32'h7FF0_0008, 32'h0, 32'hA5A5_0002, 1'b1);
    dm_op(1'b1, 32'h7FF0_0008, 32'hCAFE_F00D, 32'hA5A5_0002, 1'b1);
    dm_op(1'b0, 32'h7FF0_0008, 32'h0, 32'hCAFE_F00D, 1'b1);

    // Back-to-back DM reads, 3-cycle spacing
    c0 = cyc;
    for (int i = 0; i < 3; i++) dm_op(1'b0, 32'h7FF0_0004, 32'h0, 32'hDEAD_BEEF, 1'b1);
    check("b2b_span", 32'(cyc - c0), 32'd9);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
